// File: rtl/sched_write_reg.sv
// Register with per-write scheduled commit. Each write either commits at the
// accepting edge (delay 0) or waits in one of DEPTH countdown slots. A slot
// commits when its remaining count reaches 1 at an edge. When several commits
// land on the same edge, the most recently accepted write wins.
module sched_write_reg #(
  parameter int              WIDTH     = 4,
  parameter int              DEPTH     = 4,
  parameter int              DLY_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(4),
  parameter int              TIME_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [DLY_W-1:0]           wr_dly,
  output logic                       wr_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           data_out,
  output logic                       upd,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
  output logic                       ovf,
  output logic [TIME_W-1:0]          time_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);
  // Two slots that expire together were accepted less than 2^DLY_W writes
  // apart, so one extra bit lets a wrapping difference order them.
  localparam int SEQ_W = DLY_W + 1;

  logic [DEPTH-1:0] slot_vld;
  logic [WIDTH-1:0] slot_data [DEPTH];
  logic [DLY_W-1:0] slot_rem  [DEPTH];
  logic [SEQ_W-1:0] slot_seq  [DEPTH];
  logic [SEQ_W-1:0] seq_ctr;

  logic                    accept;
  logic                    acc_imm;
  logic                    acc_dly;
  logic [DEPTH-1:0]        vld_nxt;
  logic [DEPTH-1:0]        load;
  logic                    taken;
  logic                    found;
  logic                    commit;
  logic [WIDTH-1:0]        win_data;
  logic [SEQ_W-1:0]        win_seq;
  logic signed [SEQ_W-1:0] diff;
  logic [CNT_W-1:0]        cnt_nxt;

  // Readiness comes only from the registered occupancy count.
  assign wr_ready = (pending_cnt < CNT_W'(DEPTH));

  // Pick the commit winner, free expiring slots, and choose a slot to load.
  always_comb begin
    accept   = wr_en && wr_ready;
    acc_imm  = accept && (wr_dly == '0);
    acc_dly  = accept && (wr_dly != '0);
    vld_nxt  = slot_vld;
    load     = '0;
    taken    = 1'b0;
    found    = 1'b0;
    win_data = data_out;
    win_seq  = '0;
    diff     = '0;
    cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && (slot_rem[i] == DLY_W'(1))) begin
        vld_nxt[i] = 1'b0;
        if (!flush) begin
          diff = $signed(slot_seq[i] - win_seq);
          if (!found || (diff > 0)) begin
            found    = 1'b1;
            win_seq  = slot_seq[i];
            win_data = slot_data[i];
          end
        end
      end
    end
    commit = found;
    if (flush) vld_nxt = '0;
    // An immediate write is always the newest one at this edge.
    if (acc_imm) begin
      commit   = 1'b1;
      win_data = wr_data;
    end
    // Lowest slot that was free before this edge; freed slots wait a cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (acc_dly && !slot_vld[i] && !taken) begin
        load[i] = 1'b1;
        taken   = 1'b1;
      end
    end
    vld_nxt = vld_nxt | load;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(vld_nxt[i]);
    end
  end

  // Control state: occupancy, sequence tag, committed value, flags, counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld    <= '0;
      seq_ctr     <= '0;
      pending_cnt <= '0;
      data_out    <= RESET_VAL;
      upd         <= 1'b0;
      ovf         <= 1'b0;
      time_cnt    <= '0;
    end else begin
      slot_vld    <= vld_nxt;
      pending_cnt <= cnt_nxt;
      upd         <= commit;
      time_cnt    <= time_cnt + TIME_W'(1);
      if (acc_dly) seq_ctr <= seq_ctr + SEQ_W'(1);
      if (commit) data_out <= win_data;
      if (wr_en && !wr_ready) ovf <= 1'b1;
    end
  end

  // Slot payload: loaded on accept, counted down while occupied.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (load[i]) begin
        slot_data[i] <= wr_data;
        slot_rem[i]  <= wr_dly;
        slot_seq[i]  <= seq_ctr;
      end else if (slot_vld[i]) begin
        slot_rem[i]  <= slot_rem[i] - DLY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sched_write_reg.sv
// Bench for sched_write_reg: directed scenarios plus random traffic, checked
// each cycle against a model that keeps pending writes as absolute due times.
module tb_sched_write_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = '0;
  logic [3:0] wr_dly = '0;
  logic       flush = 1'b0;
  logic       wr_ready;
  logic [3:0] data_out;
  logic       upd;
  logic [2:0] pending_cnt;
  logic       ovf;
  logic [15:0] time_cnt;

  logic       s_ready;
  logic [3:0] s_data;
  logic       s_upd;
  logic [2:0] s_pend;
  logic       s_ovf;
  logic [3:0] s_time;

  sched_write_reg dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dly(wr_dly),
    .wr_ready(wr_ready), .flush(flush), .data_out(data_out), .upd(upd),
    .pending_cnt(pending_cnt), .ovf(ovf), .time_cnt(time_cnt)
  );

  sched_write_reg #(.TIME_W(4)) dut_t4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dly(wr_dly),
    .wr_ready(s_ready), .flush(flush), .data_out(s_data), .upd(s_upd),
    .pending_cnt(s_pend), .ovf(s_ovf), .time_cnt(s_time)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int due;
    int ord;
  } pend_t;

  pend_t q[$];
  int    mdata = 4;
  int    mupd = 0;
  int    movf = 0;
  int    ecount = 0;
  int    mord = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each pending write commits at the edge whose count equals its due.
  task automatic model_edge();
    int  best_ord;
    int  best_data;
    bit  commit;
    bit  ready;
    if (rst) begin
      q.delete();
      mdata = 4; mupd = 0; movf = 0; ecount = 0;
    end else begin
      ready = (q.size() < 4);
      if (wr_en && !ready) movf = 1;
      ecount++;
      commit = 0; best_ord = -1; best_data = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == ecount) begin
          if (!flush && q[i].ord > best_ord) begin
            best_ord = q[i].ord; best_data = q[i].data; commit = 1;
          end
          q.delete(i);
        end
      end
      if (flush) q.delete();
      if (wr_en && ready) begin
        if (wr_dly == 0) begin
          commit = 1; best_data = int'(wr_data);
        end else begin
          q.push_back('{data: int'(wr_data), due: ecount + int'(wr_dly), ord: mord});
          mord++;
        end
      end
      mupd = commit;
      if (commit) mdata = best_data;
    end
  endtask

  task automatic compare();
    chk("data_out", int'(data_out), mdata);
    chk("upd", int'(upd), mupd);
    chk("pending_cnt", int'(pending_cnt), q.size());
    chk("wr_ready", int'(wr_ready), (q.size() < 4) ? 1 : 0);
    chk("ovf", int'(ovf), movf);
    chk("time_cnt", int'(time_cnt), ecount % 65536);
    chk("time_cnt_w4", int'(s_time), ecount % 16);
  endtask

  task automatic cyc(input bit r, input bit en, input int d, input int dl, input bit fl);
    @(negedge clk);
    rst = r; wr_en = en; wr_data = 4'(d); wr_dly = 4'(dl); flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset then idle
    cyc(1, 0, 0, 0, 0);
    idle(4);
    chk("lit_reset_data", int'(data_out), 4);
    chk("lit_reset_time", int'(time_cnt), 4);
    chk("lit_reset_pend", int'(pending_cnt), 0);

    // Immediate write then a delay-3 write
    cyc(1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 1, 5, 0, 0);
    chk("lit_imm_data", int'(data_out), 5);
    chk("lit_imm_upd", int'(upd), 1);
    cyc(0, 1, 7, 3, 0);
    chk("lit_dly_pend", int'(pending_cnt), 1);
    idle(2);
    chk("lit_dly_hold", int'(data_out), 5);
    idle(1);
    chk("lit_dly_data", int'(data_out), 7);
    chk("lit_dly_upd", int'(upd), 1);

    // Two slots expiring together; later acceptance wins
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 10, 2, 0);
    cyc(0, 1, 6, 1, 0);
    idle(1);
    chk("lit_tie_data", int'(data_out), 6);
    chk("lit_tie_pend", int'(pending_cnt), 0);
    idle(1);
    chk("lit_tie_single_upd", int'(upd), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 10, 2, 0);
    cyc(0, 1, 6, 1, 0);
    cyc(0, 1, 9, 0, 0);
    chk("lit_tie_imm", int'(data_out), 9);

    // Fill all slots, then an overflowing write
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 11, 15, 0);
    cyc(0, 1, 12, 15, 0);
    cyc(0, 1, 13, 15, 0);
    cyc(0, 1, 14, 15, 0);
    cyc(0, 1, 8, 0, 0);
    chk("lit_full_ready", int'(wr_ready), 0);
    chk("lit_full_ovf", int'(ovf), 1);
    chk("lit_full_pend", int'(pending_cnt), 4);
    chk("lit_full_data", int'(data_out), 4);
    idle(10);
    chk("lit_full_wait", int'(data_out), 4);
    idle(1);
    chk("lit_full_commit", int'(data_out), 11);

    // Flush with a concurrent immediate write
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 12, 5, 0);
    cyc(0, 1, 13, 8, 0);
    cyc(0, 1, 3, 0, 1);
    chk("lit_flush_data", int'(data_out), 3);
    chk("lit_flush_pend", int'(pending_cnt), 0);
    idle(10);
    chk("lit_flush_after", int'(data_out), 3);

    // Reset with writes pending, then counter wrap on the narrow instance
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 0);
    cyc(0, 1, 2, 4, 0);
    cyc(1, 0, 0, 0, 0);
    chk("lit_rst_data", int'(data_out), 4);
    chk("lit_rst_pend", int'(pending_cnt), 0);
    idle(17);
    chk("lit_rst_nocommit", int'(data_out), 4);
    chk("lit_wrap_t4", int'(s_time), 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, en, fl;
      int dl;
      r  = ($urandom_range(0, 249) == 0);
      en = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) dl = 0;
      else if ($urandom_range(0, 4) == 0) dl = $urandom_range(1, 15);
      else dl = $urandom_range(1, 4);
      cyc(r, en, $urandom_range(0, 15), dl, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
